// File: rtl/axi_lite_arbiter_if.sv
// rtl/axi_lite_arbiter_if.sv - requester and register-bus signal bundle for axi_lite_arbiter
interface axi_lite_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_REQ    = 2
) ();

  // requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            ack;
  logic                          err;
  logic [DATA_WIDTH-1:0]         rdata;

  // register slave side
  logic                  m_awvalid;
  logic                  m_awready;
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic                  m_wvalid;
  logic                  m_wready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_wresp;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_rvalid;

  // arbiter view: drives the slave bus and the acknowledges
  modport master (
    input  req, we, addr, wdata,
    output ack, err, rdata,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_arvalid, m_araddr,
    input  m_awready, m_wready, m_wresp, m_arready, m_rdata, m_rvalid
  );

  // environment view: requesters plus the register slave
  modport slave (
    output req, we, addr, wdata,
    input  ack, err, rdata,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_arvalid, m_araddr,
    output m_awready, m_wready, m_wresp, m_arready, m_rdata, m_rvalid
  );

endinterface

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - round-robin arbiter sharing one register slave between requesters
module axi_lite_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  axi_lite_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      winner_q, winner_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  timed_out_q, timed_out_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  rr_hit;
  logic [IDX_W-1:0]      rr_idx;
  logic                  timeout_hit;

  // Round-robin scan from last_grant+1; a requester whose ack is on the wire
  // this cycle is skipped so its still-high req is not re-granted immediately.
  always_comb begin
    int cand;
    cand   = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!rr_hit && bus.req[cand] && !ack_q[cand]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(cand);
      end
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Transaction sequencer: next state, handshake valids and captured values.
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    timed_out_d  = timed_out_q;
    cnt_d        = cnt_q;
    awvalid_d    = 1'b0;
    wvalid_d     = 1'b0;
    arvalid_d    = 1'b0;
    awaddr_d     = awaddr_q;
    araddr_d     = araddr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    ack_d        = '0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_hit) begin
          winner_d     = rr_idx;
          last_grant_d = rr_idx;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          timed_out_d  = 1'b0;
          cnt_d        = '0;
          if (bus.we[rr_idx]) begin
            awaddr_d = bus.addr[rr_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_d  = bus.wdata[rr_idx*DATA_WIDTH +: DATA_WIDTH];
            state_d  = WR_REQ;
          end else begin
            araddr_d = bus.addr[rr_idx*ADDR_WIDTH +: ADDR_WIDTH];
            state_d  = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        // address and data channels retire independently
        aw_done_d = aw_done_q | (awvalid_q & bus.m_awready);
        w_done_d  = w_done_q | (wvalid_q & bus.m_wready);
        cnt_d     = cnt_q + CNT_W'(1);
        if (aw_done_d && w_done_d) begin
          cnt_d   = '0;
          state_d = WR_RESP;
        end else if (timeout_hit) begin
          timed_out_d = 1'b1;
          state_d     = DONE;
        end else begin
          awvalid_d = ~aw_done_d;
          wvalid_d  = ~w_done_d;
        end
      end

      WR_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.m_wresp) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          timed_out_d = 1'b1;
          state_d     = DONE;
        end
      end

      RD_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (arvalid_q && bus.m_arready) begin
          cnt_d   = '0;
          state_d = RD_DATA;
        end else if (timeout_hit) begin
          timed_out_d = 1'b1;
          state_d     = DONE;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      RD_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.m_rvalid) begin
          rdata_d = bus.m_rdata;
          state_d = DONE;
        end else if (timeout_hit) begin
          timed_out_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        ack_d[winner_q] = 1'b1;
        err_d           = timed_out_q;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      timed_out_q  <= 1'b0;
      cnt_q        <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      timed_out_q  <= timed_out_d;
      cnt_q        <= cnt_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      awaddr_q     <= awaddr_d;
      araddr_q     <= araddr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_araddr  = araddr_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed self-checking bench for axi_lite_arbiter
module tb_axi_lite_arbiter;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  axi_lite_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .NUM_REQ(2)) bus_if ();

  axi_lite_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .NUM_REQ(2), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register slave model, driven on the falling edge
  logic [31:0] regs [4];
  int          aw_lat, w_lat, ar_lat;
  bit          resp_en, rd_en;
  int          aw_cnt, w_cnt, ar_cnt;
  bit          aw_got, w_got, ar_got;
  logic [1:0]  wa, ra;
  logic [31:0] wd;

  always @(negedge clk) begin
    if (rst) begin
      bus_if.m_awready = 1'b0;
      bus_if.m_wready  = 1'b0;
      bus_if.m_arready = 1'b0;
      bus_if.m_wresp   = 1'b0;
      bus_if.m_rvalid  = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
    end else begin
      if (bus_if.m_wresp) begin
        bus_if.m_wresp = 1'b0;
      end else if (aw_got && w_got && !bus_if.m_awvalid && !bus_if.m_wvalid) begin
        regs[wa] = wd;
        aw_got = 0;
        w_got  = 0;
        bus_if.m_wresp = resp_en;
      end
      if (bus_if.m_rvalid) begin
        bus_if.m_rvalid = 1'b0;
      end else if (ar_got && !bus_if.m_arvalid) begin
        ar_got = 0;
        if (rd_en) begin
          bus_if.m_rvalid = 1'b1;
          bus_if.m_rdata  = regs[ra];
        end
      end
      bus_if.m_awready = 1'b0;
      if (bus_if.m_awvalid) begin
        if (aw_cnt == aw_lat) begin
          bus_if.m_awready = 1'b1;
          aw_got = 1;
          wa = bus_if.m_awaddr;
        end
        aw_cnt++;
      end else aw_cnt = 0;
      bus_if.m_wready = 1'b0;
      if (bus_if.m_wvalid) begin
        if (w_cnt == w_lat) begin
          bus_if.m_wready = 1'b1;
          w_got = 1;
          wd = bus_if.m_wdata;
        end
        w_cnt++;
      end else w_cnt = 0;
      bus_if.m_arready = 1'b0;
      if (bus_if.m_arvalid) begin
        if (ar_cnt == ar_lat) begin
          bus_if.m_arready = 1'b1;
          ar_got = 1;
          ra = bus_if.m_araddr;
        end
        ar_cnt++;
      end else ar_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit w, input logic [1:0] a, input logic [31:0] d);
    bus_if.req[i] = 1'b1;
    bus_if.we[i]  = w;
    bus_if.addr[i*2 +: 2]   = a;
    bus_if.wdata[i*32 +: 32] = d;
  endtask

  task automatic wait_ack(input int budget, output logic [1:0] a, output int cyc);
    a   = 2'b00;
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus_if.ack !== 2'b00) begin
        a   = bus_if.ack;
        cyc = i;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] a;
    int         cyc;
    int         seen;
    logic [1:0] e;

    rst = 1'b1;
    bus_if.req = '0; bus_if.we = '0; bus_if.addr = '0; bus_if.wdata = '0;
    bus_if.m_awready = 0; bus_if.m_wready = 0; bus_if.m_arready = 0;
    bus_if.m_wresp = 0; bus_if.m_rvalid = 0; bus_if.m_rdata = '0;
    aw_lat = 0; w_lat = 0; ar_lat = 0; resp_en = 1; rd_en = 1;
    for (int i = 0; i < 4; i++) regs[i] = '0;
    #2;
    // reset values
    chk("rst_ack", bus_if.ack, 0);
    chk("rst_err", bus_if.err, 0);
    chk("rst_rdata", bus_if.rdata, 0);
    chk("rst_valids", {bus_if.m_awvalid, bus_if.m_wvalid, bus_if.m_arvalid}, 0);
    chk("rst_awaddr", bus_if.m_awaddr, 0);
    chk("rst_araddr", bus_if.m_araddr, 0);
    chk("rst_wdata", bus_if.m_wdata, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single write: r0 addr 2 data DEADBEEF
    set_req(0, 1, 2'd2, 32'hDEADBEEF);
    tick();
    tick();
    chk("wr_valids_up", {bus_if.m_awvalid, bus_if.m_wvalid}, 2'b11);
    chk("wr_awaddr", bus_if.m_awaddr, 2);
    chk("wr_wdata", bus_if.m_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_valids_down", {bus_if.m_awvalid, bus_if.m_wvalid}, 2'b00);
    tick();
    chk("wr_ack_early", bus_if.ack, 2'b00);
    tick();
    chk("wr_ack", bus_if.ack, 2'b01);
    chk("wr_err", bus_if.err, 0);
    chk("wr_rdata_kept", bus_if.rdata, 0);
    bus_if.req = '0;
    tick();
    chk("wr_ack_pulse", bus_if.ack, 2'b00);
    chk("wr_reg2", regs[2], 32'hDEADBEEF);
    tick();

    // single read: r1 addr 1
    regs[1] = 32'h12345678;
    set_req(1, 0, 2'd1, 32'h0);
    tick();
    tick();
    chk("rd_arvalid", bus_if.m_arvalid, 1);
    chk("rd_araddr", bus_if.m_araddr, 1);
    tick(); tick(); tick();
    chk("rd_ack", bus_if.ack, 2'b10);
    chk("rd_rdata", bus_if.rdata, 32'h12345678);
    chk("rd_err", bus_if.err, 0);
    bus_if.req = '0;
    tick(); tick();

    // contention: both write continuously, expect 0,1,0,1
    set_req(0, 1, 2'd2, 32'hA);
    set_req(1, 1, 2'd3, 32'hB);
    for (int t = 0; t < 4; t++) begin
      e = (t % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(12, a, cyc);
      chk($sformatf("cont_ack%0d", t), a, e);
      chk($sformatf("cont_err%0d", t), bus_if.err, 0);
      if (t == 3) bus_if.req = '0;
      tick();
      chk($sformatf("cont_pulse%0d", t), bus_if.ack, 2'b00);
    end
    chk("cont_reg2", regs[2], 32'hA);
    chk("cont_reg3", regs[3], 32'hB);
    tick(); tick();

    // split handshake: wready three cycles after awready
    w_lat = 3;
    set_req(0, 1, 2'd1, 32'h55AA);
    tick();
    tick();
    chk("split_up", {bus_if.m_awvalid, bus_if.m_wvalid}, 2'b11);
    tick();
    chk("split_aw_first", {bus_if.m_awvalid, bus_if.m_wvalid}, 2'b01);
    tick(); tick();
    chk("split_w_held", {bus_if.m_awvalid, bus_if.m_wvalid}, 2'b01);
    tick();
    chk("split_w_down", {bus_if.m_awvalid, bus_if.m_wvalid}, 2'b00);
    tick();
    chk("split_ack_early", bus_if.ack, 2'b00);
    tick();
    chk("split_ack", bus_if.ack, 2'b01);
    chk("split_err", bus_if.err, 0);
    bus_if.req = '0;
    w_lat = 0;
    tick();
    chk("split_reg1", regs[1], 32'h55AA);
    tick();

    // timeout: read addr 2, slave never returns rvalid
    rd_en = 0;
    set_req(1, 0, 2'd2, 32'h0);
    tick();
    wait_ack(25, a, cyc);
    chk("to_ack", a, 2'b10);
    chk("to_cycle", cyc, 19);
    chk("to_err", bus_if.err, 1);
    chk("to_rdata_kept", bus_if.rdata, 32'h12345678);
    chk("to_arvalid", bus_if.m_arvalid, 0);
    bus_if.req = '0;
    rd_en = 1;
    tick();
    chk("to_err_pulse", bus_if.err, 0);
    tick();

    // reset while valids are stalled high
    aw_lat = 100; w_lat = 100;
    set_req(0, 1, 2'd1, 32'h33);
    tick();
    tick(); tick();
    chk("rstq_valids_hi", {bus_if.m_awvalid, bus_if.m_wvalid}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("rstq_valids_async", {bus_if.m_awvalid, bus_if.m_wvalid}, 2'b00);
    bus_if.req = '0;
    tick(); tick();
    rst = 1'b0;
    aw_lat = 0; w_lat = 0;
    tick();

    // reset in WR_RESP
    resp_en = 0;
    set_req(1, 1, 2'd0, 32'h44);
    tick();
    tick(); tick(); tick();
    chk("rstr_valids_pre", {bus_if.m_awvalid, bus_if.m_wvalid, bus_if.m_arvalid}, 3'b000);
    #2 rst = 1'b1;
    #1;
    chk("rstr_ack", bus_if.ack, 2'b00);
    chk("rstr_err", bus_if.err, 0);
    chk("rstr_valids", {bus_if.m_awvalid, bus_if.m_wvalid, bus_if.m_arvalid}, 3'b000);
    bus_if.req = '0;
    tick();
    rst = 1'b0;
    resp_en = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_if.ack !== 2'b00) seen++;
    end
    chk("rstr_no_ack", seen, 0);

    // after reset requester 0 has first priority
    set_req(0, 1, 2'd0, 32'h1234);
    set_req(1, 1, 2'd3, 32'h99);
    tick();
    tick();
    chk("prio_awaddr", bus_if.m_awaddr, 0);
    chk("prio_wdata", bus_if.m_wdata, 32'h1234);
    wait_ack(12, a, cyc);
    chk("prio_ack0", a, 2'b01);
    bus_if.req[0] = 1'b0;
    wait_ack(12, a, cyc);
    chk("prio_ack1", a, 2'b10);
    bus_if.req = '0;
    tick();
    chk("prio_reg0", regs[0], 32'h1234);
    chk("prio_reg3", regs[3], 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
